comb_gate_bist_ctrl: RTL and testbench
======================================

Name: comb_gate_bist_ctrl

Overview:
Built-in self-test sequencer for a small combinational gate cell, such as an AOI21 (out = ~((in0&in1)|in2)).
- On `start`, walks all 2**NINPUTS input vectors into the cell and holds each vector for SETTLE cycles.
- Samples the cell output on the last settle cycle of each vector and compares it against a golden truth table.
- Reports pass/fail, failure count, failing-vector map and first failing vector.
- Sits between the test-control register block and the cell under test; the gate never sees other drivers while `busy`=1.

Parameters:
- NINPUTS, 3, number of cell inputs. Vector count NVEC = 2**NINPUTS.
- SETTLE, 2, cycles each vector is held before sampling. Legal range is SETTLE >= 1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- golden  in  NVEC  expected output per vector; bit v = expected output for vector v. Latched on the accepted start.
- dut_in  out  NINPUTS  vector driven to the cell; dut_in[0]=in0, dut_in[1]=in1, dut_in[2]=in2.
- dut_out  in  1  cell output.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at the end of a run.
- pass  out  1  1 iff the last completed run had zero failures.
- fail_count  out  NINPUTS+1  number of failing vectors in the last run.
- fail_map  out  NVEC  bit v set iff vector v failed.
- first_fail_vec  out  NINPUTS  lowest-index failing vector; 0 if none.

Behaviour:
- States: IDLE, RUN, DONE. Registers: vec (NINPUTS bits), cnt (0..SETTLE-1), gold_q (NVEC bits), plus the result registers.
- Reset (reset_n=0, asynchronous, overrides everything):
  - state=IDLE; vec=0; cnt=0.
  - dut_in=0; busy=0; done=0; pass=0; fail_count=0; fail_map=0; first_fail_vec=0.
- IDLE:
  - dut_in=0, busy=0.
  - start=1 at an edge: gold_q<=golden; clear fail_count, fail_map, first_fail_vec and pass; vec<=0, cnt<=0; go to RUN.
- RUN:
  - busy=1; dut_in=vec, registered, so it changes only at edges.
  - Each edge with cnt<SETTLE-1: cnt++.
  - Edge with cnt==SETTLE-1: compare dut_out against gold_q[vec] using case equality. X or Z on dut_out counts as a failure.
  - On failure: fail_map[vec]<=1 and fail_count++. If this is the first failure of the run, first_fail_vec<=vec.
  - Same edge: if vec==NVEC-1, go to DONE; otherwise vec++ and cnt<=0. vec never wraps inside a run.
- DONE:
  - Lasts exactly one cycle with done=1 and busy=0.
  - pass is registered as (fail_count==0) on entry to DONE, so it is valid in the same cycle as done.
  - dut_in returns to 0. Next edge goes to IDLE.
- Latency: start accepted at edge k → done high in the cycle after edge k+NVEC*SETTLE. Default configuration: 17 cycles.
- start while RUN or DONE is ignored; it is not queued.
- start held high continuously gives back-to-back runs with one IDLE cycle between them.
- Results hold their values until the next accepted start or reset.
- Changing golden during RUN has no effect, because gold_q is used.
- Reset mid-run aborts the run: all outputs go to reset values, no done pulse, no partial results retained.
- fail_count width NINPUTS+1 holds NVEC without overflow.

Decomposition:
- Shared package comb_gate_bist_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam-style helpers NVEC(n) and the count width n+1;
  - default golden constant AOI21_GOLDEN = 8'h07. Vectors 0,1,2 → 1; vectors 3..7 → 0.
- One sub-module comb_gate_bist_score: result accumulator taking clear, sample_en, vec, mismatch and driving fail_count, fail_map, first_fail_vec and pass. The FSM and settle counter stay in the top module.

Test Plan:
- Golden model (default params, AOI21 attached, golden=8'h07), start pulse at edge k:
  - dut_in steps 0..7 with each value held 2 cycles;
  - done at cycle k+17;
  - pass=1, fail_count=0, fail_map=8'h00, first_fail_vec=0.
- Wrong golden: golden=8'h0F with the AOI21 attached → pass=0, fail_count=1, fail_map=8'h08, first_fail_vec=3.
- Stuck-at-0 cell model with golden=8'h07 → fail_count=3, fail_map=8'h07, first_fail_vec=0, pass=0.
- Start handling:
  - start held high across a run → no restart until after done;
  - second run begins one IDLE cycle later with results cleared at its start;
  - changing golden mid-run → results unaffected.
- Abort and instance: reset_n pulled low asynchronously while vec=4 →
  - immediately busy=0, dut_in=0, results 0, no done pulse;
  - a subsequent start gives a full correct run;
  - SETTLE=1 instance: done at k+9, each vector held 1 cycle.

Source files
------------

// File: rtl/comb_gate_bist_pkg.sv
// -----------------------------------------------------------------------------
// comb_gate_bist_pkg
// Shared types and helpers for the combinational-gate BIST sequencer.
//   state_t       : sequencer states (IDLE, RUN, DONE)
//   nvec(n)       : number of input vectors for an n-input cell (2**n)
//   count_width(n): width of a failure counter that can hold 2**n
//   AOI21_GOLDEN  : truth table of out = ~((in0&in1)|in2), bit v = vector v
// -----------------------------------------------------------------------------
package comb_gate_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nvec(input int n);
        return 1 << n;
    endfunction

    // One bit wider than the vector index so a run where every vector
    // fails does not wrap the counter.
    function automatic int count_width(input int n);
        return n + 1;
    endfunction

    localparam logic [7:0] AOI21_GOLDEN = 8'h07;

endpackage

// File: rtl/comb_gate_bist_score.sv
// -----------------------------------------------------------------------------
// comb_gate_bist_score
// Result accumulator for the BIST sequencer.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   clear          : wipe all results (start of a new run)
//   sample_en      : the current vector is being judged this edge
//   last           : the judged vector is the final one of the run
//   vec            : index of the judged vector
//   mismatch       : cell output differed from the golden value
//   pass           : run finished with zero failures (set with the last sample)
//   fail_count     : number of failing vectors
//   fail_map       : bit v set iff vector v failed
//   first_fail_vec : lowest failing vector index, 0 if none
// -----------------------------------------------------------------------------
module comb_gate_bist_score
    import comb_gate_bist_pkg::*;
#(
    parameter  int NINPUTS = 3,
    localparam int NVEC    = nvec(NINPUTS),
    localparam int CW      = count_width(NINPUTS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               sample_en,
    input  logic               last,
    input  logic [NINPUTS-1:0] vec,
    input  logic               mismatch,
    output logic               pass,
    output logic [CW-1:0]      fail_count,
    output logic [NVEC-1:0]    fail_map,
    output logic [NINPUTS-1:0] first_fail_vec
);

    logic [CW-1:0] count_next;

    // Count including the vector being judged this edge, so pass can be
    // registered on the same edge that enters DONE.
    always_comb begin
        // NOTE: default assigned first so no path leaves count_next unassigned
        // and no latch is inferred.
        count_next = fail_count;
        if (sample_en && mismatch) begin
            count_next = fail_count + CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pass           <= 1'b0;
            fail_count     <= '0;
            fail_map       <= '0;
            first_fail_vec <= '0;
        end else if (clear) begin
            pass           <= 1'b0;
            fail_count     <= '0;
            fail_map       <= '0;
            first_fail_vec <= '0;
        end else if (sample_en) begin
            fail_count <= count_next;
            if (mismatch) begin
                fail_map[vec] <= 1'b1;
                // Vectors are walked in ascending order, so the first
                // failure seen is also the lowest-index one.
                if (fail_count == '0) begin
                    first_fail_vec <= vec;
                end
            end
            if (last) begin
                pass <= (count_next == '0);
            end
        end
    end

endmodule

// File: rtl/comb_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// comb_gate_bist_ctrl
// BIST sequencer for a small combinational cell: walks every input vector,
// holds each for SETTLE cycles, samples the cell on the last settle cycle
// and scores it against a golden truth table latched at start.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   start          : run request, honoured only in IDLE
//   golden         : expected cell output per vector, latched on start
//   dut_in         : vector driven to the cell (0 outside a run)
//   dut_out        : cell output
//   busy           : run in progress
//   done           : one-cycle pulse at end of run
//   pass, fail_count, fail_map, first_fail_vec : results of the last run
// -----------------------------------------------------------------------------
module comb_gate_bist_ctrl
    import comb_gate_bist_pkg::*;
#(
    parameter  int NINPUTS = 3,
    parameter  int SETTLE  = 2,
    localparam int NVEC    = nvec(NINPUTS),
    localparam int CW      = count_width(NINPUTS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [NVEC-1:0]    golden,
    output logic [NINPUTS-1:0] dut_in,
    input  logic               dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [CW-1:0]      fail_count,
    output logic [NVEC-1:0]    fail_map,
    output logic [NINPUTS-1:0] first_fail_vec
);

    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t             state, state_next;
    logic [NINPUTS-1:0] vec;
    logic [CNTW-1:0]    cnt;
    logic [NVEC-1:0]    gold_q;

    logic accept;
    logic sample;
    logic last_vec;
    logic mismatch;

    assign accept   = (state == IDLE) && start;
    assign sample   = (state == RUN) && (cnt == CNTW'(SETTLE - 1));
    assign last_vec = (vec == NINPUTS'(NVEC - 1));
    // Case inequality so an X or Z from the cell is scored as a failure.
    assign mismatch = (dut_out !== gold_q[vec]);

    // Outputs are decoded from registers only, so they move only at edges.
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign dut_in = (state == RUN) ? vec : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (sample && last_vec) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec    <= '0;
            cnt    <= '0;
            // NOTE: gold_q is reset even though it is reloaded on every
            // start; it is a few flops, and a known value keeps mismatch
            // free of X before the first run.
            gold_q <= '0;
        end else if (accept) begin
            gold_q <= golden;
            vec    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            if (sample) begin
                cnt <= '0;
                // vec parks on the last vector rather than wrapping.
                if (!last_vec) begin
                    vec <= vec + NINPUTS'(1);
                end
            end else begin
                cnt <= cnt + CNTW'(1);
            end
        end
    end

    comb_gate_bist_score #(
        .NINPUTS (NINPUTS)
    ) u_score (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (accept),
        .sample_en      (sample),
        .last           (last_vec),
        .vec            (vec),
        .mismatch       (mismatch),
        .pass           (pass),
        .fail_count     (fail_count),
        .fail_map       (fail_map),
        .first_fail_vec (first_fail_vec)
    );

endmodule

// File: tb/tb_comb_gate_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_comb_gate_bist_ctrl
// Directed bench for comb_gate_bist_ctrl with an AOI21 (or stuck-at-0) cell
// model. Expected results are computed from a truth-table model, queued when
// a run is started and popped when done is seen.
// -----------------------------------------------------------------------------
module tb_comb_gate_bist_ctrl;
    import comb_gate_bist_pkg::*;

    typedef struct {
        logic       pass;
        logic [3:0] cnt;
        logic [7:0] map;
        logic [2:0] ffv;
    } res_t;

    res_t sb_q[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start, start1;
    logic [7:0] golden, golden1;
    logic       stuck0;

    logic [2:0] dut_in, dut_in1;
    logic       dut_out, dut_out1;
    logic       busy, busy1, done, done1, pass, pass1;
    logic [3:0] fail_count, fail_count1;
    logic [7:0] fail_map, fail_map1;
    logic [2:0] first_fail_vec, first_fail_vec1;

    int n_checks = 0;
    int n_err    = 0;

    function automatic logic aoi21(input logic [2:0] v);
        return ~((v[0] & v[1]) | v[2]);
    endfunction

    assign dut_out  = stuck0 ? 1'b0 : aoi21(dut_in);
    assign dut_out1 = aoi21(dut_in1);

    comb_gate_bist_ctrl #(.NINPUTS(3), .SETTLE(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .golden         (golden),
        .dut_in         (dut_in),
        .dut_out        (dut_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .fail_map       (fail_map),
        .first_fail_vec (first_fail_vec)
    );

    comb_gate_bist_ctrl #(.NINPUTS(3), .SETTLE(1)) dut1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start1),
        .golden         (golden1),
        .dut_in         (dut_in1),
        .dut_out        (dut_out1),
        .busy           (busy1),
        .done           (done1),
        .pass           (pass1),
        .fail_count     (fail_count1),
        .fail_map       (fail_map1),
        .first_fail_vec (first_fail_vec1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] g, input logic stuck);
        res_t r;
        r.pass = 1'b0;
        r.cnt  = '0;
        r.map  = '0;
        r.ffv  = '0;
        for (int v = 0; v < 8; v++) begin
            logic o;
            o = stuck ? 1'b0 : aoi21(3'(v));
            if (o !== g[v]) begin
                if (r.cnt == 0) r.ffv = 3'(v);
                r.map[v] = 1'b1;
                r.cnt++;
            end
        end
        r.pass = (r.cnt == 0);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full run on the SETTLE=2 instance. hold keeps start high after
    // acceptance; swap flips golden in the middle of the run.
    task automatic run_dut(input logic [7:0] g, input bit hold, input bit swap);
        res_t exp_r;
        golden = g;
        start  = 1'b1;
        sb_q.push_back(model(g, stuck0));
        step();
        if (!hold) start = 1'b0;
        check("clr_count", 32'(fail_count), 0);
        check("clr_map", 32'(fail_map), 0);
        check("clr_ffv", 32'(first_fail_vec), 0);
        check("clr_pass", 32'(pass), 0);
        for (int c = 0; c < 16; c++) begin
            check("run_dut_in", 32'(dut_in), 32'(c / 2));
            check("run_busy", 32'(busy), 1);
            check("run_no_done", 32'(done), 0);
            if (swap && c == 5) golden = ~g;
            step();
        end
        check("done", 32'(done), 1);
        check("done_busy", 32'(busy), 0);
        check("done_dut_in", 32'(dut_in), 0);
        exp_r = sb_q.pop_front();
        check("res_pass", 32'(pass), 32'(exp_r.pass));
        check("res_count", 32'(fail_count), 32'(exp_r.cnt));
        check("res_map", 32'(fail_map), 32'(exp_r.map));
        check("res_ffv", 32'(first_fail_vec), 32'(exp_r.ffv));
        step();
        check("done_pulse", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        check("hold_pass", 32'(pass), 32'(exp_r.pass));
        check("hold_count", 32'(fail_count), 32'(exp_r.cnt));
    endtask

    initial begin
        res_t r1;
        reset_n = 1'b0;
        start   = 1'b0;
        start1  = 1'b0;
        golden  = '0;
        golden1 = '0;
        stuck0  = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_dut_in", 32'(dut_in), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_count", 32'(fail_count), 0);
        check("rst_map", 32'(fail_map), 0);
        check("rst_ffv", 32'(first_fail_vec), 0);
        check("rst_busy1", 32'(busy1), 0);
        reset_n = 1'b1;
        step();

        // Good cell, correct golden.
        run_dut(AOI21_GOLDEN, 1'b0, 1'b0);
        // Wrong golden: vector 3 mismatches.
        run_dut(8'h0F, 1'b0, 1'b0);
        // Stuck-at-0 cell: vectors 0..2 fail.
        stuck0 = 1'b1;
        run_dut(AOI21_GOLDEN, 1'b0, 1'b0);
        stuck0 = 1'b0;
        // Start held across a run, second run one IDLE cycle later.
        run_dut(8'h0F, 1'b1, 1'b0);
        run_dut(AOI21_GOLDEN, 1'b0, 1'b0);
        // Golden changed mid-run has no effect.
        run_dut(AOI21_GOLDEN, 1'b0, 1'b1);

        // Abort while vec=4.
        golden = 8'h0F;
        start  = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("abort_pre_vec", 32'(dut_in), 4);
        check("abort_pre_map", 32'(fail_map), 32'h08);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_dut_in", 32'(dut_in), 0);
        check("abort_done", 32'(done), 0);
        check("abort_pass", 32'(pass), 0);
        check("abort_count", 32'(fail_count), 0);
        check("abort_map", 32'(fail_map), 0);
        check("abort_ffv", 32'(first_fail_vec), 0);
        repeat (3) begin
            step();
            check("abort_no_done", 32'(done), 0);
        end
        reset_n = 1'b1;
        step();
        run_dut(AOI21_GOLDEN, 1'b0, 1'b0);

        // SETTLE=1 instance.
        golden1 = 8'h0F;
        r1      = model(golden1, 1'b0);
        start1  = 1'b1;
        step();
        start1 = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check("s1_dut_in", 32'(dut_in1), 32'(c));
            check("s1_busy", 32'(busy1), 1);
            check("s1_no_done", 32'(done1), 0);
            step();
        end
        check("s1_done", 32'(done1), 1);
        check("s1_pass", 32'(pass1), 32'(r1.pass));
        check("s1_count", 32'(fail_count1), 32'(r1.cnt));
        check("s1_map", 32'(fail_map1), 32'(r1.map));
        check("s1_ffv", 32'(first_fail_vec1), 32'(r1.ffv));
        step();
        check("s1_done_pulse", 32'(done1), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
